systolic_setup_out: RTL

SYSTOLIC_SETUP_OUT -- requirements
Module: systolic_setup_out

---
 rtl/systolic_setup_out_pkg.sv | 13 +
 rtl/systolic_setup_out_row_fifo.sv | 65 ++++++
 rtl/systolic_setup_out.sv | 103 ++++++++++
 3 files changed

// File: rtl/systolic_setup_out_pkg.sv
// Shared defaults for the systolic array datapath stages and a small sizing helper.
package systolic_setup_out_pkg;

  localparam int unsigned DEF_DATA_SIZE = 8;
  localparam int unsigned DEF_ACC_SIZE  = 32;
  localparam int unsigned DEF_MAC_WIDTH = 256;

  // Index width that stays at least one bit for degenerate sizes.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/systolic_setup_out_row_fifo.sv
// Aligned-row output buffer: power-of-two deep, push/pop in one cycle even when full.
module row_fifo
  import systolic_setup_out_pkg::*;
#(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata_c,
  output logic             valid,
  output logic             full_c
);

  localparam int unsigned PTR_W = idx_width(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic             do_push, do_pop;

  assign full_c = (count_q == CNT_W'(DEPTH));

  always_comb begin
    do_pop   = pop && valid_q;
    do_push  = push && (!full_c || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
    valid_d = (count_d != '0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // Storage needs no reset; the read side is masked until a row is present.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata_c = valid_q ? mem_q[rd_ptr_q] : '0;
  assign valid   = valid_q;

endmodule

// File: rtl/systolic_setup_out.sv
// De-skews systolic column results into whole rows, tags frame ends and buffers rows for the consumer.
module systolic_setup_out
  import systolic_setup_out_pkg::*;
#(
  parameter int unsigned ACC_SIZE   = DEF_ACC_SIZE,
  parameter int unsigned MAC_WIDTH  = DEF_MAC_WIDTH,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [ACC_SIZE*MAC_WIDTH-1:0] col_data,
  input  logic [MAC_WIDTH-1:0]          col_valid,
  output logic [ACC_SIZE*MAC_WIDTH-1:0] row_data,
  output logic                          row_valid,
  input  logic                          row_ready,
  output logic                          row_last,
  output logic                          overflow_err,
  output logic                          skew_err
);

  localparam int unsigned ROW_W = ACC_SIZE * MAC_WIDTH;
  localparam int unsigned CNT_W = idx_width(MAC_WIDTH);

  logic [ROW_W-1:0]     al_data;
  logic [MAC_WIDTH-1:0] al_valid;

  // Column j waits MAC_WIDTH-1-j cycles so every element of a row meets the last column.
  for (genvar j = 0; j < MAC_WIDTH; j++) begin : g_col
    localparam int unsigned DLY = MAC_WIDTH - 1 - j;
    if (DLY == 0) begin : g_direct
      assign al_data[j*ACC_SIZE +: ACC_SIZE] = col_data[j*ACC_SIZE +: ACC_SIZE];
      assign al_valid[j]                     = col_valid[j];
    end else begin : g_dly
      logic [ACC_SIZE:0] stg_q [DLY];
      logic [ACC_SIZE:0] stg_d [DLY];
      always_comb begin
        stg_d[0] = {col_valid[j], col_data[j*ACC_SIZE +: ACC_SIZE]};
        for (int unsigned k = 1; k < DLY; k++) stg_d[k] = stg_q[k-1];
      end
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          for (int unsigned k = 0; k < DLY; k++) stg_q[k] <= '0;
        end else begin
          stg_q <= stg_d;
        end
      end
      assign {al_valid[j], al_data[j*ACC_SIZE +: ACC_SIZE]} = stg_q[DLY-1];
    end
  end

  logic [CNT_W-1:0] row_cnt_q, row_cnt_d;
  logic             ovf_q, ovf_d;
  logic             skew_q, skew_d;
  logic             all_v_c, mixed_v_c, pop_c, accept_c, is_last_c;
  logic             fifo_full_c, fifo_valid;
  logic [ROW_W:0]   fifo_rdata_c;

  always_comb begin
    all_v_c   = &al_valid;
    mixed_v_c = (|al_valid) && !all_v_c;
    pop_c     = fifo_valid && row_ready;
    accept_c  = all_v_c && (!fifo_full_c || pop_c);
    is_last_c = (row_cnt_q == CNT_W'(MAC_WIDTH - 1));
    row_cnt_d = row_cnt_q;
    if (accept_c) row_cnt_d = is_last_c ? '0 : row_cnt_q + CNT_W'(1);
    ovf_d  = ovf_q || (all_v_c && fifo_full_c && !pop_c);
    skew_d = skew_q || mixed_v_c;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      row_cnt_q <= '0;
      ovf_q     <= 1'b0;
      skew_q    <= 1'b0;
    end else begin
      row_cnt_q <= row_cnt_d;
      ovf_q     <= ovf_d;
      skew_q    <= skew_d;
    end
  end

  row_fifo #(
    .WIDTH (ROW_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_row_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (all_v_c),
    .pop     (pop_c),
    .wdata   ({is_last_c, al_data}),
    .rdata_c (fifo_rdata_c),
    .valid   (fifo_valid),
    .full_c  (fifo_full_c)
  );

  // The FIFO zeroes its read word when empty, so the last flag is already qualified.
  assign row_data     = fifo_rdata_c[ROW_W-1:0];
  assign row_last     = fifo_rdata_c[ROW_W];
  assign row_valid    = fifo_valid;
  assign overflow_err = ovf_q;
  assign skew_err     = skew_q;

endmodule
